sipo_fifo_wr: RTL and testbench

Serial-in/parallel-out packer that writes into a FIFO. It collects N = PARALLEL_WIDTH/SERIAL_WIDTH consecutive narrow words and writes each assembled wide word to a downstream FIFO with a one-cycle write strobe. It sits on the receive side of the 10GbE spectrometer path, where 64-bit stream words are rebuilt into 256-bit records for buffering. Words are aligned on a sync marker, FIFO-full drops are counted, and error flags are sticky.

---
 rtl/sipo_fifo_wr.sv | 90 +++++++++
 tb/tb_sipo_fifo_wr.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sipo_fifo_wr.sv
// Packs N narrow words (first word in the LSBs) into one wide word, aligned on i_sync; one fifo_we pulse 1 cycle after the last lane.
// No stall path: a completed word that meets fifo_full is dropped, counted in o_drop_cnt and flagged in o_overflow.
module sipo_fifo_wr #(
  parameter int SERIAL_WIDTH   = 64,
  parameter int PARALLEL_WIDTH = 256,
  parameter int ALIGN_ON_SYNC  = 1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [SERIAL_WIDTH-1:0]   i_serial,
  input  logic                      i_valid,
  input  logic                      i_sync,
  input  logic                      fifo_full,
  output logic                      fifo_we,
  output logic [PARALLEL_WIDTH-1:0] o_parallel,
  output logic                      o_overflow,
  output logic                      o_sync_err,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt
);

  localparam int N      = PARALLEL_WIDTH / SERIAL_WIDTH;
  localparam int LANE_W = $clog2(N);

  typedef enum logic {WAIT_SYNC, FILL} state_t;
  localparam state_t RST_STATE = (ALIGN_ON_SYNC != 0) ? WAIT_SYNC : FILL;

  state_t                    r_state, w_state_nxt;
  logic [LANE_W-1:0]         r_k, w_k_nxt, w_lane;
  logic [PARALLEL_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                      r_we, r_ovf, r_serr;
  logic [PARALLEL_WIDTH-1:0] r_parallel;
  logic [DROP_CNT_WIDTH-1:0] r_drop;
  logic                      w_accept, w_restart, w_last, w_write, w_drop, w_serr_set;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_shift_nxt = r_shift;
    // A sync word always restarts at lane 0 and pre-empts completion of the final lane.
    w_accept    = ce & i_valid & ((r_state == FILL) | i_sync);
    w_restart   = w_accept & i_sync;
    w_last      = w_accept & ~i_sync & (r_k == LANE_W'(N - 1));
    w_write     = w_last & ~fifo_full;
    w_drop      = w_last & fifo_full;
    w_serr_set  = w_restart & (r_state == FILL) & (r_k != '0);
    w_lane      = w_restart ? '0 : r_k;
    if (w_accept) begin
      for (int l = 0; l < N; l++) begin
        if (LANE_W'(l) == w_lane) w_shift_nxt[l*SERIAL_WIDTH +: SERIAL_WIDTH] = i_serial;
      end
      w_state_nxt = FILL;
      if (w_restart)   w_k_nxt = LANE_W'(1);
      else if (w_last) w_k_nxt = '0;
      else             w_k_nxt = r_k + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RST_STATE;
      r_k        <= '0;
      r_shift    <= '0;
      r_we       <= 1'b0;
      r_parallel <= '0;
      r_ovf      <= 1'b0;
      r_serr     <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_shift <= w_shift_nxt;
      r_we    <= w_write;
      if (w_write) r_parallel <= w_shift_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + DROP_CNT_WIDTH'(1);
      end
      if (w_serr_set) r_serr <= 1'b1;
    end
  end

  assign fifo_we    = r_we;
  assign o_parallel = r_parallel;
  assign o_overflow = r_ovf;
  assign o_sync_err = r_serr;
  assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_sipo_fifo_wr.sv
// Directed bench for sipo_fifo_wr with N=4 lanes and a 2-bit drop counter.
module tb_sipo_fifo_wr;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ce = 1'b1;
  logic [63:0]  i_serial = '0;
  logic         i_valid = 1'b0;
  logic         i_sync = 1'b0;
  logic         fifo_full = 1'b0;
  logic         fifo_we;
  logic [255:0] o_parallel;
  logic         o_overflow;
  logic         o_sync_err;
  logic [1:0]   o_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_we  = 0;
  int we0;
  logic [63:0] w [1:8];
  logic [63:0] a, b, c, d;

  sipo_fifo_wr #(.SERIAL_WIDTH(64), .PARALLEL_WIDTH(256), .ALIGN_ON_SYNC(1), .DROP_CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ce(ce), .i_serial(i_serial), .i_valid(i_valid), .i_sync(i_sync),
    .fifo_full(fifo_full), .fifo_we(fifo_we), .o_parallel(o_parallel), .o_overflow(o_overflow),
    .o_sync_err(o_sync_err), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fifo_we === 1'b1) n_we++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0; i_sync = 1'b0; fifo_full = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [63:0] dat, input logic s, input logic f);
    i_serial = dat; i_valid = 1'b1; i_sync = s; fifo_full = f;
    @(posedge clk); #1;
    i_valid = 1'b0; i_sync = 1'b0; fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; ce = 1'b1;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 1; i <= 8; i++) w[i] = {16{4'(i)}};
    a = 64'h0123_4567_89ab_cdef; b = 64'hdead_beef_0000_0001;
    c = 64'hcafe_f00d_1234_5678; d = 64'h8000_0000_0000_0007;

    // reset values, sampled while reset is still held
    rst = 1'b0; idle(2);
    chk("rst_we", 256'(fifo_we), 256'(0));
    chk("rst_par", o_parallel, 256'(0));
    chk("rst_flags", 256'({o_overflow, o_sync_err, o_drop_cnt}), 256'(0));
    rst = 1'b1;
    idle(1);

    // basic 4-word packing
    we0 = n_we;
    send(w[1], 1, 0); send(w[2], 0, 0); send(w[3], 0, 0);
    chk("t1_no_early_we", 256'(fifo_we), 256'(0));
    send(w[4], 0, 0);
    chk("t1_we", 256'(fifo_we), 256'(1));
    chk("t1_par", o_parallel, {w[4], w[3], w[2], w[1]});
    chk("t1_flags", 256'({o_overflow, o_sync_err, o_drop_cnt}), 256'(0));
    idle(1);
    chk("t1_we_pulse", 256'(fifo_we), 256'(0));
    chk("t1_par_hold", o_parallel, {w[4], w[3], w[2], w[1]});

    // pre-sync words ignored; valid gaps and ce low mid-word
    do_reset();
    we0 = n_we;
    send(w[5], 0, 0); send(w[6], 0, 0); send(w[7], 0, 0); send(w[8], 0, 0); send(w[5], 0, 0);
    idle(1);
    chk("t2_presync_nowrite", 256'(n_we - we0), 256'(0));
    send(w[1], 1, 0); idle(2);
    send(w[2], 0, 0);
    ce = 1'b0; i_valid = 1'b1; i_serial = a;
    repeat (2) begin @(posedge clk); #1; end
    ce = 1'b1; i_valid = 1'b0;
    send(w[3], 0, 0); idle(3);
    send(w[4], 0, 0);
    chk("t2_we", 256'(fifo_we), 256'(1));
    chk("t2_par", o_parallel, {w[4], w[3], w[2], w[1]});
    idle(2);
    chk("t2_one_write", 256'(n_we - we0), 256'(1));

    // drop on fifo_full, then a normal write
    we0 = n_we;
    send(w[5], 1, 0); send(w[6], 0, 0); send(w[7], 0, 0); send(w[8], 0, 1);
    chk("t3_no_we", 256'(fifo_we), 256'(0));
    chk("t3_par_unchanged", o_parallel, {w[4], w[3], w[2], w[1]});
    chk("t3_ovf", 256'(o_overflow), 256'(1));
    chk("t3_drop1", 256'(o_drop_cnt), 256'(1));
    chk("t3_no_serr", 256'(o_sync_err), 256'(0));
    send(a, 0, 0); send(b, 0, 0); send(c, 0, 0); send(d, 0, 0);
    chk("t3_next_we", 256'(fifo_we), 256'(1));
    chk("t3_next_par", o_parallel, {d, c, b, a});
    idle(1);
    chk("t3_ovf_sticky", 256'(o_overflow), 256'(1));
    chk("t3_writes", 256'(n_we - we0), 256'(1));

    // sync with a partial word pending
    do_reset();
    we0 = n_we;
    send(w[1], 1, 0); send(w[2], 0, 0);
    send(w[5], 1, 0);
    chk("t4_serr", 256'(o_sync_err), 256'(1));
    send(w[6], 0, 0); send(w[7], 0, 0); send(w[8], 0, 0);
    chk("t4_par", o_parallel, {w[8], w[7], w[6], w[5]});
    chk("t4_drop0", 256'(o_drop_cnt), 256'(0));
    idle(1);
    chk("t4_one_write", 256'(n_we - we0), 256'(1));

    // sync on the last lane slot pre-empts completion
    do_reset();
    we0 = n_we;
    send(w[1], 1, 0); send(w[2], 0, 0); send(w[3], 0, 0); send(w[5], 1, 0);
    chk("t5_no_we", 256'(fifo_we), 256'(0));
    chk("t5_serr", 256'(o_sync_err), 256'(1));
    send(w[6], 0, 0); send(w[7], 0, 0); send(w[8], 0, 0);
    chk("t5_par", o_parallel, {w[8], w[7], w[6], w[5]});
    idle(1);
    chk("t5_one_write", 256'(n_we - we0), 256'(1));

    // drop counter saturation
    do_reset();
    we0 = n_we;
    for (int g = 0; g < 5; g++) begin
      send(w[1], (g == 0), 0); send(w[2], 0, 0); send(w[3], 0, 0); send(w[4], 0, 1);
      if (g == 1) chk("t6_drop2", 256'(o_drop_cnt), 256'(2));
    end
    chk("t6_drop_sat", 256'(o_drop_cnt), 256'(3));
    chk("t6_no_writes", 256'(n_we - we0), 256'(0));
    chk("t6_par_zero", o_parallel, 256'(0));

    // async reset after 3 lanes, and during a fifo_we cycle
    do_reset();
    send(w[1], 1, 0); send(w[2], 0, 0); send(w[3], 0, 0);
    #1 rst = 1'b0; #1;
    chk("t7_mid_flags", 256'({o_overflow, o_sync_err, o_drop_cnt, fifo_we}), 256'(0));
    idle(1);
    rst = 1'b1;
    send(w[5], 1, 0); send(w[6], 0, 0); send(w[7], 0, 0); send(w[8], 0, 0);
    chk("t7_we", 256'(fifo_we), 256'(1));
    chk("t7_par_fresh", o_parallel, {w[8], w[7], w[6], w[5]});
    #1 rst = 1'b0; #1;
    chk("t7_we_cancel", 256'(fifo_we), 256'(0));
    chk("t7_par_clr", o_parallel, 256'(0));
    idle(1);
    rst = 1'b1;
    we0 = n_we;
    send(a, 1, 0); send(b, 0, 0); send(c, 0, 0); send(d, 0, 0);
    chk("t7_after_par", o_parallel, {d, c, b, a});
    idle(1);
    chk("t7_after_one", 256'(n_we - we0), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
